spu_fetch_unit: RTL

Dual-issue instruction fetch stage. It holds the fetch PC and issues 8-byte-aligned instruction-pair requests to the instruction local store. Returned pairs are buffered in a small in-order fetch queue, and the head pair is presented to the IF/ID pipeline register as PC_adderOut/instruction1/instruction2. It also handles decode-side stall back-pressure and branch redirects, discarding wrong-path responses that are still in flight.

---
 rtl/spu_fetch_pkg.sv | 23 ++
 rtl/spu_fetch_queue.sv | 58 +++++
 rtl/spu_fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/spu_fetch_pkg.sv
// spu_fetch_pkg: shared types and constants for the SPU dual-issue fetch stage.
//   FETCH_BYTES   - bytes per instruction pair (one fetch request)
//   fetch_pair_t  - queued pair: {address+8, first word, second word}
//   cnt_width()   - width of a 0..depth counter
package spu_fetch_pkg;

   localparam int PC_BITS       = 32;
   localparam int FQ_DEPTH_DFLT = 4;
   localparam int FETCH_BYTES   = 8;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int CNT_W = cnt_width(FQ_DEPTH_DFLT);

   typedef struct packed {
      logic [PC_BITS-1:0] pc_plus8;
      logic [31:0]        instr1;
      logic [31:0]        instr2;
   } fetch_pair_t;

endpackage

// File: rtl/spu_fetch_queue.sv
// spu_fetch_queue: small synchronous FIFO with flush.
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   push_i       - write data_i (caller must not push when full unless popping)
//   pop_i        - drop the head entry (ignored when empty)
//   flush_i      - discard all entries; wins over push/pop
//   head_o       - oldest entry (combinational read)
//   empty_o, full_o, count_o - occupancy status
module spu_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic                         flush_i,
   input  logic [DW-1:0]                data_i,
   output logic [DW-1:0]                head_o,
   output logic                         empty_o,
   output logic                         full_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic          push_ok, pop_ok;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign push_ok = push_i && !flush_i;
   assign pop_ok  = pop_i && !empty_o && !flush_i;

   // Storage is not reset; entries are only visible through count.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   // DEPTH is a power of two, so pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/spu_fetch_unit.sv
// spu_fetch_unit: dual-issue instruction fetch stage.
//   clk, reset                 - rising-edge clock, synchronous active-high reset
//   imem_req/addr/ready        - 8-byte pair request to instruction local store
//   imem_rvalid/rdata          - in-order responses, [63:32] = word at addr
//   stall                      - decode back-pressure, holds the head pair
//   redirect/redirect_pc       - branch/flush, new fetch address (low 3 bits ignored)
//   fetch_valid, PC_adderOut,
//   instruction1/instruction2  - head pair towards IF/ID (zero when empty)
module spu_fetch_unit
   import spu_fetch_pkg::*;
#(
   parameter int                   PCbitsize = PC_BITS,
   parameter int                   FQ_DEPTH  = FQ_DEPTH_DFLT,
   parameter logic [PCbitsize-1:0] RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 imem_req,
   output logic [PCbitsize-1:0] imem_addr,
   input  logic                 imem_ready,
   input  logic                 imem_rvalid,
   input  logic [63:0]          imem_rdata,
   input  logic                 stall,
   input  logic                 redirect,
   input  logic [PCbitsize-1:0] redirect_pc,
   output logic                 fetch_valid,
   output logic [PCbitsize-1:0] PC_adderOut,
   output logic [31:0]          instruction1,
   output logic [31:0]          instruction2
);

   localparam int CW = cnt_width(FQ_DEPTH);
   localparam int SW = CW + 1;
   localparam int PW = $bits(fetch_pair_t);

   logic [PCbitsize-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]        drop_q, drop_d;
   logic [CW-1:0]        fq_cnt, out_cnt;
   logic                 fq_empty, fq_full, af_empty, af_full;
   logic [PCbitsize-1:0] af_head;
   fetch_pair_t          fq_in, fq_head;
   logic                 credit_ok, accept, resp, keep, pop, push;

   // Queued pairs plus in-flight requests never exceed the queue, so every
   // response always has a slot. af_full is redundant with this but cheap.
   assign credit_ok = ((SW'(fq_cnt) + SW'(out_cnt)) < SW'(FQ_DEPTH)) && !af_full;
   assign imem_req  = !reset && !redirect && credit_ok;
   assign imem_addr = fetch_pc_q;
   assign accept    = imem_req && imem_ready;

   assign resp = imem_rvalid && !af_empty;
   // A response arriving in a redirect cycle is wrong-path and is discarded.
   assign keep = resp && (drop_q == '0) && !redirect;
   assign pop  = !fq_empty && !stall && !redirect;
   assign push = keep && (!fq_full || pop);

   assign fq_in = '{pc_plus8: af_head,
                    instr1:   imem_rdata[63:32],
                    instr2:   imem_rdata[31:0]};

   // In-flight request addresses (already +8); its count is the outstanding count.
   spu_fetch_queue #(.DEPTH(FQ_DEPTH), .DW(PCbitsize)) u_addr_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (accept),
      .pop_i   (resp),
      .flush_i (1'b0),
      .data_i  (fetch_pc_q + PCbitsize'(FETCH_BYTES)),
      .head_o  (af_head),
      .empty_o (af_empty),
      .full_o  (af_full),
      .count_o (out_cnt)
   );

   spu_fetch_queue #(.DEPTH(FQ_DEPTH), .DW(PW)) u_fetch_q (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect),
      .data_i  (fq_in),
      .head_o  (fq_head),
      .empty_o (fq_empty),
      .full_o  (fq_full),
      .count_o (fq_cnt)
   );

   assign fetch_valid  = !fq_empty;
   assign PC_adderOut  = fq_empty ? '0 : fq_head.pc_plus8;
   assign instruction1 = fq_empty ? '0 : fq_head.instr1;
   assign instruction2 = fq_empty ? '0 : fq_head.instr2;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      if (redirect) begin
         fetch_pc_d = {redirect_pc[PCbitsize-1:3], 3'b000};
         // Everything still in flight after this cycle is wrong-path.
         drop_d     = out_cnt - CW'(resp);
      end else begin
         if (accept) fetch_pc_d = fetch_pc_q + PCbitsize'(FETCH_BYTES);
         if (resp && (drop_q != '0)) drop_d = drop_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
      end
   end

endmodule
